// File: rtl/sparse_line_expander.sv
// Rebuilds a full 32-lane line from a lane mask and a stream of packed words;
// masked-out lanes are zero-filled, lane i takes the packed word at its exclusive prefix count.
module sparse_line_expander #(
  parameter int unsigned WORD_WIDTH = 8,
  parameter int unsigned BEAT_WORDS = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             mask_valid,
  output logic                             mask_ready,
  input  logic [31:0]                      mask,
  input  logic                             pk_valid,
  output logic                             pk_ready,
  input  logic [BEAT_WORDS*WORD_WIDTH-1:0] pk_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [32*WORD_WIDTH-1:0]         out_data,
  output logic [31:0]                      out_mask
);

  localparam int unsigned LANES      = 32;
  localparam int unsigned CW         = 6;
  localparam int unsigned LW         = LANES * WORD_WIDTH;
  localparam int unsigned BEAT_SHIFT = (BEAT_WORDS > 1) ? $clog2(BEAT_WORDS) : 0;

  typedef enum logic [1:0] {IDLE, FILL, OUT} state_t;

  state_t                  state_q, state_d;
  logic [LANES-1:0]        mask_q, mask_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [CW-1:0]           nb_q, nb_d;
  logic [CW-1:0]           beat_idx_q, beat_idx_d;
  logic [WORD_WIDTH-1:0]   buf_q [LANES];
  logic [WORD_WIDTH-1:0]   buf_d [LANES];
  logic [LW-1:0]           out_data_q, out_data_d;
  logic [LANES-1:0]        out_mask_q, out_mask_d;

  logic                    mask_fire, pk_fire, out_fire;
  logic [CW-1:0]           in_cnt, in_nb;
  logic [CW-1:0]           prefix [LANES];
  logic [CW-1:0]           prefix_acc;
  logic                    prefix_msb_unused;
  logic [CW-1:0]           base, slot;
  logic [LW-1:0]           line;

  function automatic logic [CW-1:0] popcount(input logic [LANES-1:0] v);
    logic [CW-1:0] s;
    s = '0;
    for (int i = 0; i < LANES; i++) s = s + CW'(v[i]);
    return s;
  endfunction

  assign mask_ready = (state_q == IDLE) || ((state_q == OUT) && out_ready);
  assign pk_ready   = (state_q == FILL);
  assign out_valid  = (state_q == OUT);
  assign out_data   = out_data_q;
  assign out_mask   = out_mask_q;

  assign mask_fire = mask_valid && mask_ready;
  assign pk_fire   = pk_valid && pk_ready;
  assign out_fire  = out_valid && out_ready;

  assign in_cnt = popcount(mask);
  assign in_nb  = CW'((in_cnt + CW'(BEAT_WORDS - 1)) >> BEAT_SHIFT);

  // Exclusive prefix count of the captured mask: destination slot per lane.
  always_comb begin
    prefix_acc        = '0;
    prefix_msb_unused = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      prefix[i]         = prefix_acc;
      prefix_msb_unused = prefix_msb_unused ^ prefix_acc[CW-1];
      prefix_acc        = prefix_acc + CW'(mask_q[i]);
    end
  end

  // Packed buffer with the current beat merged in; words past cnt are dropped.
  always_comb begin
    base = beat_idx_q << BEAT_SHIFT;
    slot = '0;
    for (int j = 0; j < LANES; j++) buf_d[j] = buf_q[j];
    for (int k = 0; k < BEAT_WORDS; k++) begin
      slot = base + CW'(k);
      if (pk_fire && (slot < cnt_q)) buf_d[slot[4:0]] = pk_data[k*WORD_WIDTH +: WORD_WIDTH];
    end
  end

  // Set lanes only ever read slots below cnt, so stale buffer words never leak.
  always_comb begin
    line = '0;
    for (int i = 0; i < LANES; i++) begin
      if (mask_q[i]) line[i*WORD_WIDTH +: WORD_WIDTH] = buf_d[prefix[i][4:0]];
    end
  end

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    cnt_d      = cnt_q;
    nb_d       = nb_q;
    beat_idx_d = beat_idx_q;
    out_data_d = out_data_q;
    out_mask_d = out_mask_q;

    case (state_q)
      IDLE: ;
      FILL: begin
        if (pk_fire) begin
          beat_idx_d = beat_idx_q + CW'(1);
          if (beat_idx_q == nb_q - CW'(1)) begin
            state_d    = OUT;
            out_data_d = line;
            out_mask_d = mask_q;
          end
        end
      end
      OUT: begin
        if (out_fire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A new mask can land in IDLE or on the handoff cycle of OUT.
    if (mask_fire) begin
      mask_d     = mask;
      cnt_d      = in_cnt;
      nb_d       = in_nb;
      beat_idx_d = '0;
      if (in_cnt == '0) begin
        state_d    = OUT;
        out_data_d = '0;
        out_mask_d = mask;
      end else begin
        state_d = FILL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      mask_q     <= '0;
      cnt_q      <= '0;
      nb_q       <= '0;
      beat_idx_q <= '0;
      out_data_q <= '0;
      out_mask_q <= '0;
      for (int j = 0; j < LANES; j++) buf_q[j] <= '0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      cnt_q      <= cnt_d;
      nb_q       <= nb_d;
      beat_idx_q <= beat_idx_d;
      out_data_q <= out_data_d;
      out_mask_q <= out_mask_d;
      for (int j = 0; j < LANES; j++) buf_q[j] <= buf_d[j];
    end
  end

endmodule

// File: tb/tb_sparse_line_expander.sv
// Self-checking bench: transaction-level model of mask/beat/line handshakes plus directed literal checks.
module tb_sparse_line_expander;

  localparam int WW = 8;
  localparam int BW = 4;

  logic           clk;
  logic           reset;
  logic           mask_valid;
  logic           mask_ready;
  logic [31:0]    mask;
  logic           pk_valid;
  logic           pk_ready;
  logic [BW*WW-1:0] pk_data;
  logic           out_valid;
  logic           out_ready;
  logic [32*WW-1:0] out_data;
  logic [31:0]    out_mask;

  sparse_line_expander #(.WORD_WIDTH(WW), .BEAT_WORDS(BW)) dut (
    .clk(clk), .reset(reset),
    .mask_valid(mask_valid), .mask_ready(mask_ready), .mask(mask),
    .pk_valid(pk_valid), .pk_ready(pk_ready), .pk_data(pk_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_mask(out_mask)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Model state: a line is pending, or words are being collected for the current mask.
  logic             model_ok = 1'b0;
  logic             m_valid = 1'b0;
  logic             m_coll = 1'b0;
  logic [32*WW-1:0] m_data = '0;
  logic [31:0]      m_mask = '0;
  logic [31:0]      m_cur = '0;
  int               m_cnt = 0;
  logic [WW-1:0]    m_words[$];
  logic             m_mfire = 1'b0;
  logic             m_pfire = 1'b0;

  task automatic chk(input string name, input logic [32*WW-1:0] act, input logic [32*WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_step();
    logic mr;
    int   p;
    m_mfire = 1'b0;
    m_pfire = 1'b0;
    if (reset) begin
      m_valid = 1'b0; m_coll = 1'b0; m_data = '0; m_mask = '0; m_cnt = 0;
      m_words.delete();
      model_ok = 1'b1;
    end else begin
      mr = !m_coll && (!m_valid || out_ready);
      if (m_valid && out_ready) m_valid = 1'b0;
      if (m_coll && pk_valid) begin
        m_pfire = 1'b1;
        for (int k = 0; k < BW; k++) m_words.push_back(pk_data[k*WW +: WW]);
        if (m_words.size() >= m_cnt) begin
          m_data = '0;
          p = 0;
          for (int i = 0; i < 32; i++) begin
            if (m_cur[i]) begin
              m_data[i*WW +: WW] = m_words[p];
              p++;
            end
          end
          m_mask  = m_cur;
          m_valid = 1'b1;
          m_coll  = 1'b0;
        end
      end
      if (mask_valid && mr) begin
        m_mfire = 1'b1;
        m_cur   = mask;
        m_cnt   = $countones(mask);
        m_words.delete();
        if (m_cnt == 0) begin
          m_data  = '0;
          m_mask  = mask;
          m_valid = 1'b1;
        end else begin
          m_coll = 1'b1;
        end
      end
    end
  endtask

  // Compare all outputs at the falling edge, then advance the model for the coming rising edge.
  task automatic cycle();
    @(negedge clk);
    if (model_ok) begin
      chk("out_valid", (32*WW)'(out_valid), (32*WW)'(m_valid));
      chk("pk_ready", (32*WW)'(pk_ready), (32*WW)'(m_coll));
      chk("mask_ready", (32*WW)'(mask_ready), (32*WW)'(!m_coll && (!m_valid || out_ready)));
      chk("out_data", out_data, m_data);
      chk("out_mask", (32*WW)'(out_mask), (32*WW)'(m_mask));
    end
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_mask(input logic [31:0] m);
    int n = 0;
    mask_valid = 1'b1;
    mask = m;
    do begin cycle(); n++; end while (!m_mfire && n < 100);
    mask_valid = 1'b0;
    if (!m_mfire) chk("mask_accept_timeout", 0, 1);
  endtask

  task automatic drive_beat(input logic [BW*WW-1:0] d);
    int n = 0;
    pk_valid = 1'b1;
    pk_data = d;
    do begin cycle(); n++; end while (!m_pfire && n < 100);
    pk_valid = 1'b0;
    if (!m_pfire) chk("beat_accept_timeout", 0, 1);
  endtask

  logic [32*WW-1:0] ed;
  logic [31:0] rm;

  initial begin
    reset = 1'b1; mask_valid = 1'b0; mask = '0; pk_valid = 1'b0; pk_data = '0; out_ready = 1'b1;
    cycle(); cycle();
    reset = 1'b0;
    chk("rst_out_valid", (32*WW)'(out_valid), 0);
    chk("rst_mask_ready", (32*WW)'(mask_ready), 1);
    chk("rst_pk_ready", (32*WW)'(pk_ready), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_mask", (32*WW)'(out_mask), 0);

    // single lane
    drive_mask(32'h0000_0001);
    drive_beat(32'hDDCC_BBAA);
    chk("t1_out_valid", (32*WW)'(out_valid), 1);
    chk("t1_out_data", out_data, (32*WW)'(8'hAA));
    chk("t1_out_mask", (32*WW)'(out_mask), 32'h1);
    cycle();

    // all ones: 8 beats, lane i = i
    drive_mask(32'hFFFF_FFFF);
    for (int b = 0; b < 8; b++)
      drive_beat({8'(4*b+3), 8'(4*b+2), 8'(4*b+1), 8'(4*b)});
    for (int i = 0; i < 32; i++) ed[i*WW +: WW] = 8'(i);
    chk("t2_out_valid", (32*WW)'(out_valid), 1);
    chk("t2_out_data", out_data, ed);
    pk_valid = 1'b1;
    chk("t2_no_ninth_beat", (32*WW)'(pk_ready), 0);
    cycle();
    chk("t2_no_ninth_beat_idle", (32*WW)'(pk_ready), 0);
    pk_valid = 1'b0;

    // empty mask
    drive_mask(32'h0);
    chk("t3_out_valid", (32*WW)'(out_valid), 1);
    chk("t3_pk_ready", (32*WW)'(pk_ready), 0);
    chk("t3_out_data", out_data, 0);
    cycle();

    // truncated final beat, then no stale data
    drive_mask(32'h8000_0005);
    drive_beat(32'h4433_2211);
    ed = '0; ed[0 +: 8] = 8'h11; ed[2*WW +: 8] = 8'h22; ed[31*WW +: 8] = 8'h33;
    chk("t4_out_data", out_data, ed);
    chk("t4_out_mask", (32*WW)'(out_mask), 32'h8000_0005);
    cycle();
    drive_mask(32'h0000_0002);
    drive_beat(32'h9988_7755);
    ed = '0; ed[1*WW +: 8] = 8'h55;
    chk("t4_no_stale", out_data, ed);
    cycle();

    // backpressure then handoff with same-cycle mask accept
    cycle();
    out_ready = 1'b0;
    drive_mask(32'h0000_0003);
    drive_beat(32'h0000_B2A1);
    ed = '0; ed[0 +: 8] = 8'hA1; ed[1*WW +: 8] = 8'hB2;
    for (int c = 0; c < 5; c++) begin
      chk("t5_hold_data", out_data, ed);
      chk("t5_hold_mask", (32*WW)'(out_mask), 32'h3);
      chk("t5_hold_pk_ready", (32*WW)'(pk_ready), 0);
      chk("t5_hold_mask_ready", (32*WW)'(mask_ready), 0);
      cycle();
    end
    out_ready = 1'b1;
    drive_mask(32'h0000_0003);
    chk("t5_fill_pk_ready", (32*WW)'(pk_ready), 1);
    chk("t5_fill_out_valid", (32*WW)'(out_valid), 0);
    drive_beat(32'h0000_D4C3);
    ed = '0; ed[0 +: 8] = 8'hC3; ed[1*WW +: 8] = 8'hD4;
    chk("t5_second_line", out_data, ed);
    cycle();

    // reset mid-fill
    drive_mask(32'hFFFF_FFFF);
    for (int b = 0; b < 3; b++) drive_beat(32'h0101_0101 * (b + 1));
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("t6_out_valid", (32*WW)'(out_valid), 0);
    chk("t6_out_data", out_data, 0);
    chk("t6_mask_ready", (32*WW)'(mask_ready), 1);
    chk("t6_pk_ready", (32*WW)'(pk_ready), 0);
    drive_mask(32'h0000_0001);
    drive_beat(32'h0000_007E);
    chk("t6_lane0", out_data, (32*WW)'(8'h7E));
    cycle();

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      case ($urandom_range(0, 4))
        0: rm = 32'h0;
        1: rm = 32'hFFFF_FFFF;
        2: rm = $urandom;
        3: rm = 32'h1 << $urandom_range(0, 31);
        default: rm = $urandom & $urandom & $urandom;
      endcase
      mask       = rm;
      mask_valid = ($urandom_range(0, 3) == 0);
      pk_valid   = ($urandom_range(0, 3) != 0);
      pk_data    = $urandom;
      out_ready  = ($urandom_range(0, 2) != 0);
      reset      = ($urandom_range(0, 399) == 0);
      cycle();
    end
    reset = 1'b0; mask_valid = 1'b0; pk_valid = 1'b0;
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sparse_line_expander.md
Name: sparse_line_expander

Overview:
- Decompression end of the redundancy-removal path: takes a 32-bit lane mask plus a stream of packed (non-redundant) words and rebuilds the full 32-lane line. Masked-out lanes are zero-filled.
- Each lane's destination index is its exclusive prefix count of mask ones (the same 6-bit prefix-count convention the compaction side uses).
- Sits between the packed-data buffer and the downstream lane array. Valid/ready on all three interfaces.

Parameters:
- WORD_WIDTH, 8, bit width of one data word.
- BEAT_WORDS, 4, packed words delivered per input beat; must be a power of two from 1 to 32.

Ports:
- clk  input  1  clock, all logic rising-edge.
- reset  input  1  synchronous, active-high reset.
- mask_valid  input  1  mask offered.
- mask_ready  output  1  mask accepted when mask_valid && mask_ready.
- mask  input  32  lane mask; bit i = 1 means lane i carries a packed word.
- pk_valid  input  1  packed beat offered.
- pk_ready  output  1  beat accepted when pk_valid && pk_ready.
- pk_data  input  BEAT_WORDS*WORD_WIDTH  packed words; word k at [k*WORD_WIDTH +: WORD_WIDTH], word 0 is the lowest packed index.
- out_valid  output  1  expanded line valid.
- out_ready  input  1  downstream accepts line.
- out_data  output  32*WORD_WIDTH  lane i at [i*WORD_WIDTH +: WORD_WIDTH].
- out_mask  output  32  mask of the line currently on out_data.

Behaviour:
- Reset: state=IDLE. mask_ready=1, pk_ready=0, out_valid=0, out_data=0, out_mask=0. Internal counters and buffer are cleared. Reset wins over every other event in the same cycle.
- Mask capture: on acceptance, register mask and compute cnt=popcount(mask) (0..32, 6 bits).
  - Required beats: nb = ceil(cnt/BEAT_WORDS).
  - Compute a 6-bit exclusive prefix count per lane.
- States:
  - IDLE: mask_ready=1. On mask accept, go to FILL if cnt>0, else go to OUT.
  - FILL: pk_ready=1 and mask_ready=0. Each accepted beat writes its words into packed buffer slots beat_idx*BEAT_WORDS+k, and beat_idx increments. On the beat where beat_idx==nb-1, go to OUT.
  - OUT: out_valid=1. out_data and out_mask are stable while out_valid && !out_ready.
- Final-beat handling: words in the final beat at packed index >= cnt are discarded.
- Buffer: 32 words, cleared only by reset.
  - Slots at or beyond cnt are never read.
  - Stale contents from a previous line must not appear on any lane.
- Expansion timing: out_data is registered on the cycle of entry to OUT.
  - Lane i = packed[prefix_i] if mask bit i is 1, else 0.
  - If the final beat is accepted in cycle t, out_valid=1 in cycle t+1.
  - If cnt=0, the mask is accepted in cycle t, out_valid=1 in t+1 and out_data=0.
- Leaving OUT: the line is handed off when out_valid && out_ready.
  - In that same cycle mask_ready=1, so mask_ready = (state==IDLE) || (state==OUT && out_ready).
  - If a new mask is accepted in that cycle, go to FILL, or re-enter OUT if its cnt=0 (new data is registered).
  - Otherwise go to IDLE, where out_valid=0 and out_data holds its last value.
- pk_ready=0 outside FILL. pk_valid outside FILL is ignored and does not stall.
- Width rules:
  - popcount and prefix counts are 6-bit; beat_idx is 6-bit.
  - An all-ones mask gives cnt=32 and nb=32/BEAT_WORDS.

Test Plan:
- mask=0x00000001, one beat {0xAA,0xBB,0xCC,0xDD} -> out_valid one cycle after the beat; lane0=0xAA, lanes1..31=0; out_mask=0x00000001.
- mask=0xFFFFFFFF, 8 beats carrying packed words 0..31 -> exactly 8 pk handshakes; lane i = i for all i.
- mask=0x00000000 -> pk_ready never asserted; out_valid in the cycle after mask accept; out_data all zero.
- mask=0x80000005, one beat {0x11,0x22,0x33,0x44} -> lane0=0x11, lane2=0x22, lane31=0x33, all other lanes 0; 0x44 is discarded. Then send mask=0x00000002 with beat {0x55,...} -> lane1=0x55 and lane31=0, so no stale data.
- Hold out_ready=0 for 5 cycles in OUT -> out_data and out_mask stable, pk_ready=0, mask_ready=0. Then raise out_ready together with mask_valid (mask=0x3) -> handoff and mask accept in the same cycle, and FILL is entered.
- Assert reset after 3 of 8 beats of an all-ones line -> next cycle IDLE, out_valid=0, out_data=0, mask_ready=1. A following mask=0x1 with beat {0x7E,...} -> lane0=0x7E.
